cpu_control_sequencer: RTL and testbench

//  Multi-cycle control FSM for the tiny RISC-V CPU. Fetches a 32-bit word from

---
 rtl/cpu_ctrl_pkg.sv | 21 ++
 rtl/cpu_control_sequencer.sv | 133 +++++++++++++
 tb/tb_cpu_control_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the tiny RISC-V multi-cycle control sequencer.
// State encodings, reset NOP and counter widths.
package cpu_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_FETCH     = 3'd1;
  localparam state_t ST_DECODE    = 3'd2;
  localparam state_t ST_EXECUTE   = 3'd3;
  localparam state_t ST_WRITEBACK = 3'd4;
  localparam state_t ST_HALT      = 3'd5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int EXEC_CNTW    = 4;
  localparam int TIMEOUT_CNTW = 8;
  localparam int SEQ_CNTW     =
    (EXEC_CNTW > TIMEOUT_CNTW) ? EXEC_CNTW : TIMEOUT_CNTW;

endpackage

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle control FSM: fetch over req/ready, decode, timed execute,
// and a single gated writeback cycle per instruction.
module cpu_control_sequencer #(
  parameter int EXEC_CYCLES   = 1,
  parameter int FETCH_TIMEOUT = 16,
  parameter int CNTW          = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic            halt_req,
  input  logic            imem_ready,
  input  logic [31:0]     imem_instr,
  input  logic            dec_writeenable,
  input  logic [1:0]      dec_pcfunc,
  output logic            imem_req,
  output logic [31:0]     instruction,
  output logic            rf_we,
  output logic            pc_update,
  output logic [1:0]      pcfunc_out,
  output logic            busy,
  output logic            halted,
  output logic            fault,
  output logic [CNTW-1:0] retired
);

  import cpu_ctrl_pkg::*;

  localparam logic [SEQ_CNTW-1:0] EXEC_LOAD =
    SEQ_CNTW'(EXEC_CYCLES - 1);
  localparam logic [SEQ_CNTW-1:0] TIMEOUT_LAST =
    SEQ_CNTW'(FETCH_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [SEQ_CNTW-1:0] cnt_q, cnt_d;
  logic [31:0]         instr_q, instr_d;
  logic                fault_q, fault_d;
  logic [CNTW-1:0]     retired_q, retired_d;

  logic in_wb;

  // One down/up counter serves both the fetch wait and execute window.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    fault_d   = fault_q;
    retired_d = retired_q;
    unique case (state_q)
      ST_IDLE: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (run) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
        end
      end
      ST_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_instr;
          state_d = ST_DECODE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          cnt_d = cnt_q + SEQ_CNTW'(1);
        end
      end
      ST_DECODE: begin
        state_d = ST_EXECUTE;
        cnt_d   = EXEC_LOAD;
      end
      ST_EXECUTE: begin
        if (cnt_q == '0) begin
          state_d = ST_WRITEBACK;
        end else begin
          cnt_d = cnt_q - SEQ_CNTW'(1);
        end
      end
      ST_WRITEBACK: begin
        retired_d = retired_q + CNTW'(1);
        cnt_d     = '0;
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (!halt_req && !run) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      instr_q   <= NOP_INSTR;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  // Strobes decode the registered state, so reset clears them at once.
  assign in_wb       = (state_q == ST_WRITEBACK);
  assign imem_req    = (state_q == ST_FETCH);
  assign rf_we       = in_wb & dec_writeenable;
  assign pc_update   = in_wb;
  assign pcfunc_out  = in_wb ? dec_pcfunc : 2'b00;
  assign busy        = (state_q == ST_FETCH)
                     | (state_q == ST_DECODE)
                     | (state_q == ST_EXECUTE)
                     | in_wb;
  assign halted      = (state_q == ST_HALT);
  assign instruction = instr_q;
  assign fault       = fault_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for cpu_control_sequencer: vector table through a scoreboard queue
// plus hand-written fetch-wait, timeout, halt and reset sequences.
module tb_cpu_control_sequencer;

  localparam logic [31:0] N  = 32'h0000_0013;
  localparam logic [31:0] I0 = 32'h0050_0093;
  localparam logic [31:0] J0 = 32'h00a0_0113;
  localparam logic [31:0] A0 = 32'h1111_1111;
  localparam logic [31:0] B0 = 32'h2222_2222;
  localparam logic [31:0] C0 = 32'h3333_3333;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        halt_req = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_instr = '0;
  logic        dec_writeenable = 1'b0;
  logic [1:0]  dec_pcfunc = 2'b00;

  logic        imem_req, rf_we, pc_update, busy, halted, fault;
  logic [31:0] instruction, retired;
  logic [1:0]  pcfunc_out;

  logic        s_req, s_rf, s_pc, s_busy, s_halted, s_fault;
  logic [31:0] s_instr, s_retired;
  logic [1:0]  s_pcf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  cpu_control_sequencer #(
    .EXEC_CYCLES(1), .FETCH_TIMEOUT(16), .CNTW(32)
  ) dut (
    .clock(clock), .reset(reset), .run(run), .halt_req(halt_req),
    .imem_ready(imem_ready), .imem_instr(imem_instr),
    .dec_writeenable(dec_writeenable), .dec_pcfunc(dec_pcfunc),
    .imem_req(imem_req), .instruction(instruction), .rf_we(rf_we),
    .pc_update(pc_update), .pcfunc_out(pcfunc_out), .busy(busy),
    .halted(halted), .fault(fault), .retired(retired)
  );

  cpu_control_sequencer #(
    .EXEC_CYCLES(3), .FETCH_TIMEOUT(4), .CNTW(32)
  ) dut_slow (
    .clock(clock), .reset(reset), .run(run), .halt_req(halt_req),
    .imem_ready(imem_ready), .imem_instr(imem_instr),
    .dec_writeenable(dec_writeenable), .dec_pcfunc(dec_pcfunc),
    .imem_req(s_req), .instruction(s_instr), .rf_we(s_rf),
    .pc_update(s_pc), .pcfunc_out(s_pcf), .busy(s_busy),
    .halted(s_halted), .fault(s_fault), .retired(s_retired)
  );

  typedef struct {
    logic        r;
    logic        h;
    logic        rdy;
    logic [31:0] im;
    logic        dwe;
    logic [1:0]  pcf;
    logic [47:0] ex;
  } vec_t;

  localparam int NV = 19;
  vec_t vec [NV];
  logic [63:0] exp_q [$];

  function automatic logic [47:0] e(
    logic req, logic rf, logic pc, logic [1:0] pcf,
    logic bz, logic hl, logic fl, logic [7:0] ret, logic [31:0] ins);
    return {req, rf, pc, pcf, bz, hl, fl, ret, ins};
  endfunction

  function automatic vec_t mk(
    logic r, logic h, logic rdy, logic [31:0] im,
    logic dwe, logic [1:0] pcf, logic [47:0] ex);
    vec_t v;
    v.r = r; v.h = h; v.rdy = rdy; v.im = im;
    v.dwe = dwe; v.pcf = pcf; v.ex = ex;
    return v;
  endfunction

  function automatic logic [47:0] obs();
    return {imem_req, rf_we, pc_update, pcfunc_out, busy,
            halted, fault, retired[7:0], instruction};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exv);
    n_cmp++;
    if (act !== exv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exv);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run = 1'b0; halt_req = 1'b0; imem_ready = 1'b0;
    imem_instr = '0; dec_writeenable = 1'b0; dec_pcfunc = 2'b00;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqs, rfs, pcs;
    logic ok;
    logic [63:0] ev;

    vec[0]  = mk(1,0,1,I0,1,1, e(0,0,0,0,0,0,0,0,N));
    vec[1]  = mk(1,0,1,I0,1,1, e(1,0,0,0,1,0,0,0,N));
    vec[2]  = mk(1,0,1,I0,1,1, e(0,0,0,0,1,0,0,0,I0));
    vec[3]  = mk(1,0,1,I0,1,1, e(0,0,0,0,1,0,0,0,I0));
    vec[4]  = mk(1,0,1,I0,1,1, e(0,1,1,1,1,0,0,0,I0));
    vec[5]  = mk(1,0,1,I0,1,1, e(1,0,0,0,1,0,0,1,I0));
    vec[6]  = mk(1,0,1,I0,1,1, e(0,0,0,0,1,0,0,1,I0));
    vec[7]  = mk(1,0,1,I0,1,1, e(0,0,0,0,1,0,0,1,I0));
    vec[8]  = mk(1,0,1,I0,1,1, e(0,1,1,1,1,0,0,1,I0));
    vec[9]  = mk(1,0,1,I0,1,1, e(1,0,0,0,1,0,0,2,I0));
    vec[10] = mk(1,0,1,I0,1,1, e(0,0,0,0,1,0,0,2,I0));
    vec[11] = mk(1,0,1,I0,1,1, e(0,0,0,0,1,0,0,2,I0));
    vec[12] = mk(1,0,1,I0,0,2, e(0,0,1,2,1,0,0,2,I0));
    vec[13] = mk(1,0,1,J0,1,0, e(1,0,0,0,1,0,0,3,I0));
    vec[14] = mk(1,0,1,J0,1,0, e(0,0,0,0,1,0,0,3,J0));
    vec[15] = mk(1,0,1,J0,1,0, e(0,0,0,0,1,0,0,3,J0));
    vec[16] = mk(0,0,1,J0,1,3, e(0,1,1,3,1,0,0,3,J0));
    vec[17] = mk(0,0,0,J0,1,3, e(0,0,0,0,0,0,0,4,J0));
    vec[18] = mk(0,0,0,J0,1,3, e(0,0,0,0,0,0,0,4,J0));

    // back-to-back instructions through the scoreboard
    do_reset();
    for (int i = 0; i < NV; i++) begin
      run = vec[i].r; halt_req = vec[i].h; imem_ready = vec[i].rdy;
      imem_instr = vec[i].im; dec_writeenable = vec[i].dwe;
      dec_pcfunc = vec[i].pcf;
      exp_q.push_back({16'h0, vec[i].ex});
      #1;
      ev = exp_q.pop_front();
      chk($sformatf("vec%0d", i), {16'h0, obs()}, ev);
      @(negedge clock);
    end

    // fetch held for five wait cycles
    do_reset();
    run = 1; dec_writeenable = 1; imem_instr = A0;
    @(negedge clock);
    for (int k = 0; k < 6; k++) begin
      imem_ready = (k == 5);
      imem_instr = (k == 5) ? B0 : A0;
      #1 chk($sformatf("wait%0d", k), {imem_req, fault, instruction},
             {1'b1, 1'b0, N});
      @(negedge clock);
    end
    imem_ready = 0;
    #1 chk("wait_done", {imem_req, busy, fault, instruction},
           {1'b0, 1'b1, 1'b0, B0});
    @(negedge clock); @(negedge clock);
    #1 chk("wait_wb", {rf_we, pc_update}, 2'b11);
    run = 0;
    @(negedge clock);
    #1 chk("wait_ret", retired, 32'd1);

    // fetch timeout
    do_reset();
    run = 1;
    @(negedge clock);
    ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1 if (!(imem_req && !halted && !fault)) ok = 1'b0;
      @(negedge clock);
    end
    chk("to_wait16", {63'h0, ok}, 64'h1);
    #1 chk("to_fault", {halted, fault, imem_req, busy, instruction},
           {1'b1, 1'b1, 1'b0, 1'b0, N});
    @(negedge clock);
    #1 chk("to_stay", {halted, imem_req}, 2'b10);
    run = 0;
    @(negedge clock);
    #1 chk("to_exit", {halted, fault, busy}, 3'b010);
    run = 1; imem_ready = 1;
    @(negedge clock);
    #1 chk("to_refetch", {imem_req, fault}, 2'b11);

    // ready on the final allowed wait cycle wins
    do_reset();
    run = 1;
    @(negedge clock);
    repeat (15) @(negedge clock);
    imem_ready = 1; imem_instr = C0;
    @(negedge clock);
    #1 chk("last_ready", {fault, halted, busy, instruction},
           {1'b0, 1'b0, 1'b1, C0});

    // halt raised in execute
    do_reset();
    run = 1; imem_ready = 1; imem_instr = I0; dec_writeenable = 1;
    repeat (3) @(negedge clock);
    halt_req = 1;
    @(negedge clock);
    #1 chk("halt_wb", {rf_we, pc_update}, 2'b11);
    reqs = 0; rfs = 0; pcs = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      #1;
      reqs += int'(imem_req); rfs += int'(rf_we); pcs += int'(pc_update);
    end
    chk("halt_after", {reqs[7:0], rfs[7:0], pcs[7:0], 7'h0, halted,
                       retired}, {24'h0, 8'h01, 32'd1});

    // asynchronous reset mid-execute
    do_reset();
    run = 1; imem_ready = 1; imem_instr = I0; dec_writeenable = 1;
    repeat (5) @(negedge clock);
    #1 chk("rst_pre", retired, 32'd1);
    @(negedge clock); @(negedge clock);
    #2 reset = 0;
    #1 chk("rst_async", {16'h0, obs()}, {16'h0, e(0,0,0,0,0,0,0,0,N)});
    @(negedge clock);
    #1 chk("rst_hold", {rf_we, pc_update, busy, retired},
           {3'b000, 32'd0});

    // slow instance: three execute cycles, timeout of four
    do_reset();
    run = 1; imem_ready = 1; dec_writeenable = 1;
    for (int k = 0; k < 14; k++) begin
      exp_q.push_back({63'h0, (k == 6 || k == 12)});
      #1;
      ev = exp_q.pop_front();
      chk($sformatf("slow_pc%0d", k), {63'h0, s_pc}, ev);
      @(negedge clock);
    end
    #1 chk("slow_ret", s_retired, 32'd2);
    do_reset();
    run = 1;
    repeat (4) @(negedge clock);
    #1 chk("slow_to4", {s_req, s_halted, s_fault}, 3'b100);
    @(negedge clock);
    #1 chk("slow_to5", {s_req, s_halted, s_fault}, 3'b011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
